// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, run/lap/pause FSM, 1 Hz count clock, display mux.
// Optional STOPWATCH_AUTOSTOP_EN pauses the stopwatch instead of wrapping past 59:59.
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DB_CYCLES  = 1_000_000,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        btn_ss,
    input  logic        btn_lc,
    input  logic [15:0] bcd_in,
    output logic        clk1hz_o,
    output logic        actv_o,
    output logic        tmr_rstn_o,
    output logic [15:0] disp_bcd,
    output logic        lap_vld,
    output logic [2:0]  state_o
);

    localparam int unsigned PRE_W = $clog2(CLK_HZ);
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2 - 1);
    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DB_CYCLES - 1);
    localparam logic [CLR_W-1:0] CLR_MAX  = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        StClear = 3'd0,
        StIdle  = 3'd1,
        StRun   = 3'd2,
        StLap   = 3'd3,
        StPause = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Debounce: bit 0 = start/stop, bit 1 = lap/clear
    // ------------------------------------------------------------------
    logic [1:0]      w_btn;
    logic [1:0]      r_sync0;
    logic [1:0]      r_sync1;
    logic [1:0]      r_stb;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_press;
    logic            w_ss;
    logic            w_lc;

    assign w_btn = {btn_lc, btn_ss};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_stb   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync0 <= w_btn;
            r_sync1 <= r_sync0;
            for (int i = 0; i < 2; i++) begin
                if (r_sync1[i] != r_stb[i]) begin
                    if (r_db_cnt[i] == DB_MAX) begin
                        r_stb[i]    <= r_sync1[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press pulse fires in the cycle whose edge flips the stable level 0->1.
    always_comb begin
        w_press = '0;
        for (int i = 0; i < 2; i++) begin
            w_press[i] = r_sync1[i] & ~r_stb[i] & (r_db_cnt[i] == DB_MAX);
        end
    end

    assign w_ss = w_press[0];
    assign w_lc = w_press[1] & ~w_press[0];

    // ------------------------------------------------------------------
    // FSM, prescaler and registered outputs
    // ------------------------------------------------------------------
    state_e           r_state;
    state_e           w_state_d;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [CLR_W-1:0] w_clr_cnt_d;
    logic [15:0]      r_lap;
    logic [15:0]      w_lap_d;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_d;
    logic             r_clk1hz;
    logic             w_clk1hz_d;
    logic             r_actv;
    logic             r_lap_vld;
    logic             r_tmr_rstn;
    logic             w_counting;

    assign w_counting = (r_state == StRun) || (r_state == StLap);

    always_comb begin
        w_state_d   = r_state;
        w_clr_cnt_d = r_clr_cnt;
        w_lap_d     = r_lap;
        w_pre_d     = r_pre;
        w_clk1hz_d  = r_clk1hz;

        unique case (r_state)
            StClear: begin
                w_lap_d = '0;
                if (r_clr_cnt == CLR_MAX) begin
                    w_state_d   = StIdle;
                    w_clr_cnt_d = '0;
                end else begin
                    w_clr_cnt_d = r_clr_cnt + 1'b1;
                end
            end
            StIdle: begin
                if (w_ss) begin
                    w_state_d = StRun;
                end else if (w_lc) begin
                    w_state_d = StClear;
                end
            end
            StRun: begin
                if (w_ss) begin
                    w_state_d = StPause;
                end else if (w_lc) begin
                    w_state_d = StLap;
                    w_lap_d   = bcd_in;
                end
            end
            StLap: begin
                if (w_ss) begin
                    w_state_d = StPause;
                end else if (w_lc) begin
                    w_state_d = StRun;
                end
            end
            StPause: begin
                if (w_ss) begin
                    w_state_d = StRun;
                end else if (w_lc) begin
                    w_state_d = StClear;
                end
            end
            default: begin
                w_state_d   = StClear;
                w_clr_cnt_d = '0;
            end
        endcase

        // Prescaler runs while the counter runs, freezes in PAUSE, else parked at zero.
        if (w_counting) begin
            w_pre_d = (r_pre == PRE_MAX) ? '0 : r_pre + 1'b1;
            if (r_pre == PRE_MAX) begin
                w_clk1hz_d = 1'b1;
            end else if (r_pre == PRE_HALF) begin
                w_clk1hz_d = 1'b0;
            end
        end else if (r_state != StPause) begin
            w_pre_d    = '0;
            w_clk1hz_d = 1'b0;
        end

`ifdef STOPWATCH_AUTOSTOP_EN
        // At 59:59 the rising edge that would roll the counter is swallowed.
        if (w_counting && (r_pre == PRE_MAX) && (bcd_in == 16'h5959)) begin
            w_pre_d    = '0;
            w_clk1hz_d = 1'b0;
            w_state_d  = StPause;
            w_lap_d    = r_lap;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StClear;
            r_clr_cnt  <= '0;
            r_lap      <= '0;
            r_pre      <= '0;
            r_clk1hz   <= 1'b0;
            r_actv     <= 1'b0;
            r_lap_vld  <= 1'b0;
            r_tmr_rstn <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_clr_cnt  <= w_clr_cnt_d;
            r_lap      <= w_lap_d;
            r_pre      <= w_pre_d;
            r_clk1hz   <= w_clk1hz_d;
            r_actv     <= (w_state_d == StRun) || (w_state_d == StLap);
            r_lap_vld  <= (w_state_d == StLap);
            r_tmr_rstn <= (w_state_d != StClear);
        end
    end

    assign clk1hz_o   = r_clk1hz;
    assign actv_o     = r_actv;
    assign tmr_rstn_o = r_tmr_rstn;
    assign lap_vld    = r_lap_vld;
    assign state_o    = r_state;
    assign disp_bcd   = (r_state == StLap) ? r_lap : bcd_in;

endmodule
